// File: rtl/regs_if.sv
// -----------------------------------------------------------------------------
// regs_if -- bus bundle between the pipeline (id/ex stages) and the register
// file.
//
// Signals:
//   reg1_raddr_i / reg2_raddr_i  read addresses (rs1 / rs2 from the id stage)
//   reg1_rdata_o / reg2_rdata_o  read data returned by the register file
//   reg_waddr_i / reg_wdata_i    write address / data (ex stage rd_addr/rd_data)
//   reg_wen_i                    write enable (ex stage rd_wen)
//   regs_ready_o                 register file finished its clear sequence
//
// Modports:
//   master  pipeline side: drives addresses and writes, observes data/ready
//   slave   register file side
// -----------------------------------------------------------------------------
interface regs_if;
  logic [4:0]  reg1_raddr_i;
  logic [4:0]  reg2_raddr_i;
  logic [31:0] reg1_rdata_o;
  logic [31:0] reg2_rdata_o;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_wen_i;
  logic        regs_ready_o;

  modport master (
    output reg1_raddr_i, reg2_raddr_i, reg_waddr_i, reg_wdata_i, reg_wen_i,
    input  reg1_rdata_o, reg2_rdata_o, regs_ready_o
  );

  modport slave (
    input  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, reg_wdata_i, reg_wen_i,
    output reg1_rdata_o, reg2_rdata_o, regs_ready_o
  );
endinterface

// File: rtl/regs.sv
// -----------------------------------------------------------------------------
// regs -- 31 x 32-bit integer register file (x1..x31, x0 hard-wired to zero)
// with two combinational read ports, one write port and a post-reset clear
// sequence that loads CLR_VALUE into every register, one per clock.
//
// Ports:
//   clk  single clock, all state changes on its rising edge
//   rst  synchronous active-high reset; restarts the clear sequence
//   bus  regs_if.slave: read ports, write port, regs_ready_o
//
// Parameter:
//   CLR_VALUE  value written into x1..x31 by the clear sequence
//
// Optional feature:
//   REGS_BYPASS_EN  when defined, a write in flight is forwarded to any read
//                   port addressing the same (non-zero) register in the same
//                   cycle. Default build: reads return stored values only.
// -----------------------------------------------------------------------------
module regs #(
  parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  regs_if.slave bus
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]  state;
  logic [4:0]  clr_cnt;
  logic        ready_q;
  logic [31:0] mem [1:31];
  logic        run_active;
  logic        wr_commit;

  // Reads and writes are only honoured once the clear sequence is complete
  // and reset is not being held; this also keeps uncleared storage (X) from
  // ever reaching the read ports.
  assign run_active = (state == RUN) && !rst;
  assign wr_commit  = run_active && bus.reg_wen_i && (bus.reg_waddr_i != 5'd0);

  // Control: CLEAR walks clr_cnt from 1 up to 31, then parks in RUN.
  // clr_cnt holds at 31 in RUN so it never wraps back onto x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= 5'd1;
      ready_q <= 1'b0;
    end else if (state == CLEAR) begin
      if (clr_cnt == 5'd31) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + 5'd1;
      end
    end
  end

  // Storage: the clear sequence owns the array in CLEAR, the write port owns
  // it in RUN. Reset itself leaves the contents alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= CLR_VALUE;
      end else if (wr_commit) begin
        mem[bus.reg_waddr_i] <= bus.reg_wdata_i;
      end
    end
  end

  assign bus.regs_ready_o = ready_q;

  // Read port 1: zero-latency lookup, x0 and non-RUN cycles read as zero.
  always_comb begin
    bus.reg1_rdata_o = 32'h0;
    if (run_active && (bus.reg1_raddr_i != 5'd0)) begin
`ifdef REGS_BYPASS_EN
      if (wr_commit && (bus.reg_waddr_i == bus.reg1_raddr_i)) begin
        bus.reg1_rdata_o = bus.reg_wdata_i;
      end else begin
        bus.reg1_rdata_o = mem[bus.reg1_raddr_i];
      end
`else
      bus.reg1_rdata_o = mem[bus.reg1_raddr_i];
`endif
    end
  end

  // Read port 2: identical to port 1 but fully independent of it.
  always_comb begin
    bus.reg2_rdata_o = 32'h0;
    if (run_active && (bus.reg2_raddr_i != 5'd0)) begin
`ifdef REGS_BYPASS_EN
      if (wr_commit && (bus.reg_waddr_i == bus.reg2_raddr_i)) begin
        bus.reg2_rdata_o = bus.reg_wdata_i;
      end else begin
        bus.reg2_rdata_o = mem[bus.reg2_raddr_i];
      end
`else
      bus.reg2_rdata_o = mem[bus.reg2_raddr_i];
`endif
    end
  end

endmodule

// File: tb/tb_regs.sv
// -----------------------------------------------------------------------------
// tb_regs -- directed testbench for regs (CLR_VALUE = 32'hDEAD_BEEF).
// Covers reset state, the 31-edge clear sequence, dropped writes during
// clear, write/read, x0 guard, same-cycle forwarding (build dependent on
// REGS_BYPASS_EN) and reset in the middle of RUN.
// -----------------------------------------------------------------------------
module tb_regs;

  localparam logic [31:0] CLR = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  regs_if bus ();

  regs #(.CLR_VALUE(CLR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the write port and both read addresses in one go.
  task automatic apply_stimulus(input logic wen, input logic [4:0] waddr,
                                input logic [31:0] wdata,
                                input logic [4:0] r1, input logic [4:0] r2);
    bus.reg_wen_i    = wen;
    bus.reg_waddr_i  = waddr;
    bus.reg_wdata_i  = wdata;
    bus.reg1_raddr_i = r1;
    bus.reg2_raddr_i = r2;
  endtask

  // Advance to just after the next rising edge.
  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] exp_val;
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);

    // Two edges with reset held: not ready, reads forced to zero.
    wait_edge();
    check_output("rst_ready_0", {31'h0, bus.regs_ready_o}, 32'h0);
    wait_edge();
    check_output("rst_ready_1", {31'h0, bus.regs_ready_o}, 32'h0);
    check_output("rst_rd1", bus.reg1_rdata_o, 32'h0);
    check_output("rst_rd2", bus.reg2_rdata_o, 32'h0);

    // Release and count edges; ready must rise on exactly the 31st.
    // A write to x3 on the 10th edge must be dropped.
    rst = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      if (n == 10) begin
        apply_stimulus(1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
        #1;
        check_output("clear_rd1_zero", bus.reg1_rdata_o, 32'h0);
        check_output("clear_rd2_zero", bus.reg2_rdata_o, 32'h0);
      end else begin
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      end
      wait_edge();
      check_output($sformatf("clear_ready_e%0d", n), {31'h0, bus.regs_ready_o},
                   (n == 31) ? 32'h1 : 32'h0);
    end

    // Every register reads CLR (including x3 after the dropped write), x0 reads 0.
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check_output($sformatf("clr_rd1_x%0d", i), bus.reg1_rdata_o,
                   (i == 0) ? 32'h0 : CLR);
      check_output($sformatf("clr_rd2_x%0d", 31 - i), bus.reg2_rdata_o,
                   (i == 31) ? 32'h0 : CLR);
    end

    // Write x5, read it back on both ports next cycle.
    apply_stimulus(1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0);
    wait_edge();
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    check_output("wr_x5_rd1", bus.reg1_rdata_o, 32'h1234_5678);
    check_output("wr_x5_rd2", bus.reg2_rdata_o, 32'h1234_5678);

    // x0 guard: write is discarded, same cycle and after.
    apply_stimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    check_output("x0_same_rd1", bus.reg1_rdata_o, 32'h0);
    check_output("x0_same_rd2", bus.reg2_rdata_o, 32'h0);
    wait_edge();
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check_output("x0_next_rd1", bus.reg1_rdata_o, 32'h0);

    // Forwarding: zero x7 first, then write while port 2 watches it.
    apply_stimulus(1'b1, 5'd7, 32'h0, 5'd0, 5'd0);
    wait_edge();
    apply_stimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd0, 5'd7);
    #1;
`ifdef REGS_BYPASS_EN
    exp_val = 32'hA5A5_A5A5;
`else
    exp_val = 32'h0;
`endif
    check_output("byp_same_rd2", bus.reg2_rdata_o, exp_val);
    check_output("byp_same_rd1_x0", bus.reg1_rdata_o, 32'h0);
    wait_edge();
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1;
    check_output("byp_next_rd1", bus.reg1_rdata_o, 32'hA5A5_A5A5);
    check_output("byp_next_rd2", bus.reg2_rdata_o, 32'hA5A5_A5A5);

    // Reset in RUN: x9 written, then one reset cycle re-runs the clear.
    apply_stimulus(1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    wait_edge();
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    check_output("run_x9", bus.reg1_rdata_o, 32'h99);
    rst = 1'b1;
    wait_edge();
    check_output("rerst_ready", {31'h0, bus.regs_ready_o}, 32'h0);
    check_output("rerst_rd1", bus.reg1_rdata_o, 32'h0);
    rst = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      wait_edge();
      check_output($sformatf("reclear_ready_e%0d", n), {31'h0, bus.regs_ready_o},
                   (n == 31) ? 32'h1 : 32'h0);
    end
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    #1;
    check_output("reclear_x9", bus.reg1_rdata_o, CLR);
    check_output("reclear_x5", bus.reg2_rdata_o, CLR);
    apply_stimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    #1;
    check_output("reclear_x7", bus.reg1_rdata_o, CLR);
    check_output("reclear_x0", bus.reg2_rdata_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
